// File: rtl/ldpc_ram_pkg.sv
// ldpc_ram_pkg
// Shared constants for the banked LDPC read RAM: the names of the selectable
// RAM implementation styles, the legal upper limits for lane count and skid
// depth, and a helper used by the elaboration-time parameter checks.
// No ports (package).
package ldpc_ram_pkg;

  localparam string RES_BLOCK_RAM   = "block_ram";
  localparam string RES_DISTRIBUTED = "distributed";
  localparam string RES_REGISTERS   = "registers";

  localparam int MAX_LANES = 8;
  localparam int MAX_SKID  = 16;

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/ldpc_skid_fifo.sv
// ldpc_skid_fifo
// Show-ahead FIFO holding read data for one output lane. The head entry is
// always visible on popData_o; pointers wrap naturally because the depth is a
// power of two.
// Ports:
//   clock_i, reset_i   clock and synchronous active-high reset
//   push_i, pushData_i write one entry (caller guarantees space)
//   pop_i              remove the head entry (ignored when empty)
//   popData_o          head entry, meaningful only when empty_o is low
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries (0..SKID_DEPTH)
module ldpc_skid_fifo
  import ldpc_ram_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              pushData_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              popData_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(SKID_DEPTH):0]   count_o
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;

  if (!isPow2(SKID_DEPTH) || SKID_DEPTH < 2 || SKID_DEPTH > MAX_SKID) begin : gBadDepth
    $error("ldpc_skid_fifo: SKID_DEPTH must be a power of two in 2..%0d", MAX_SKID);
  end

  logic [WIDTH-1:0] storage_q [SKID_DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             popEn;

  assign popEn     = pop_i & ~empty_o;
  assign popData_o = storage_q[rdPtr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(SKID_DEPTH));
  assign count_o   = count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({push_i, popEn})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock_i) begin
    if (push_i) storage_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/ldpc_banked_ram.sv
// ldpc_banked_ram
// Single-write, multi-read RAM for LDPC decoders. Every write is broadcast to
// one private RAM copy per read lane, so each lane reads independently with
// its own ready/valid flow control. A lane accepts a request only while its
// credit (FIFO occupancy plus the in-flight read) is below SKID_DEPTH, so the
// per-lane skid FIFO can never overflow and no data is ever dropped.
// Ports:
//   i_clock, i_reset           clock and synchronous active-high reset
//   i_in_data/addr/valid       write port, no backpressure
//   i_out_addr                 per-lane read address, lane k at [k*AW +: AW]
//   i_out_addr_valid / o_out_addr_ready   per-lane request handshake
//   o_out_data                 per-lane read data, lane k at [k*WIDTH +: WIDTH]
//   o_out_valid / i_out_ready  per-lane response handshake
module ldpc_banked_ram
  import ldpc_ram_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter int    DEPTH      = 1024,
  parameter int    LANES      = 2,
  parameter int    SKID_DEPTH = 4,
  parameter string RESOURCE   = "block_ram",
  localparam int   AW         = $clog2(DEPTH)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_in_data,
  input  logic [AW-1:0]          i_in_addr,
  input  logic                   i_in_valid,
  input  logic [LANES*AW-1:0]    i_out_addr,
  input  logic [LANES-1:0]       i_out_addr_valid,
  output logic [LANES-1:0]       o_out_addr_ready,
  output logic [LANES*WIDTH-1:0] o_out_data,
  output logic [LANES-1:0]       o_out_valid,
  input  logic [LANES-1:0]       i_out_ready
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;

  if (LANES < 1 || LANES > MAX_LANES) begin : gBadLanes
    $error("ldpc_banked_ram: LANES must be in 1..%0d", MAX_LANES);
  end
  if (!isPow2(SKID_DEPTH) || SKID_DEPTH < 2 || SKID_DEPTH > MAX_SKID) begin : gBadSkid
    $error("ldpc_banked_ram: SKID_DEPTH must be a power of two in 2..%0d", MAX_SKID);
  end
  if (DEPTH < 2) begin : gBadDepth
    $error("ldpc_banked_ram: DEPTH must be at least 2");
  end
  if (RESOURCE != RES_BLOCK_RAM && RESOURCE != RES_DISTRIBUTED &&
      RESOURCE != RES_REGISTERS) begin : gBadResource
    $error("ldpc_banked_ram: unknown RESOURCE style");
  end

  for (genvar k = 0; k < LANES; k++) begin : gLane
    logic [AW-1:0]    rdAddr;
    logic             accept;
    logic             pop;
    logic             inflight_q;
    logic             ready_q;
    logic             ready_d;
    logic [WIDTH-1:0] rdData_q;
    logic [WIDTH-1:0] headData;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CW-1:0]    fifoCount;
    logic [CW-1:0]    credit;
    logic [CW-1:0]    credit_d;

    assign rdAddr = i_out_addr[k*AW +: AW];

    // Outputs are forced low during reset; otherwise ready comes straight
    // from a register so it has no combinational path from the lane inputs.
    assign o_out_addr_ready[k]         = ready_q & ~i_reset;
    assign o_out_valid[k]              = ~fifoEmpty & ~i_reset;
    assign o_out_data[k*WIDTH +: WIDTH] = headData;

    assign accept = i_out_addr_valid[k] & o_out_addr_ready[k];
    assign pop    = o_out_valid[k] & i_out_ready[k];
    assign credit = fifoCount + CW'(inflight_q);

    always_comb begin
      credit_d = credit;
      if (accept && !pop)      credit_d = credit + CW'(1);
      else if (!accept && pop) credit_d = credit - CW'(1);
      ready_d = (credit_d < CW'(SKID_DEPTH));
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        inflight_q <= 1'b0;
        ready_q    <= 1'b0;
      end else begin
        inflight_q <= accept;
        ready_q    <= ready_d;
      end
    end

    // Private RAM copy for this lane. Writes ignore reset so contents survive
    // it; the read uses the pre-write value on a same-address collision.
    if (RESOURCE == RES_BLOCK_RAM) begin : gBram
      (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge i_clock) begin
        if (i_in_valid) mem_q[i_in_addr] <= i_in_data;
      end
      always_ff @(posedge i_clock) begin
        if (accept) rdData_q <= mem_q[rdAddr];
      end
    end else if (RESOURCE == RES_DISTRIBUTED) begin : gDist
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge i_clock) begin
        if (i_in_valid) mem_q[i_in_addr] <= i_in_data;
      end
      always_ff @(posedge i_clock) begin
        if (accept) rdData_q <= mem_q[rdAddr];
      end
    end else begin : gRegs
      (* ram_style = "registers" *) logic [WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge i_clock) begin
        if (i_in_valid) mem_q[i_in_addr] <= i_in_data;
      end
      always_ff @(posedge i_clock) begin
        if (accept) rdData_q <= mem_q[rdAddr];
      end
    end

    ldpc_skid_fifo #(
      .WIDTH      (WIDTH),
      .SKID_DEPTH (SKID_DEPTH)
    ) uFifo (
      .clock_i    (i_clock),
      .reset_i    (i_reset),
      .push_i     (inflight_q),
      .pushData_i (rdData_q),
      .pop_i      (pop),
      .popData_o  (headData),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .count_o    (fifoCount)
    );

    // Credit accounting guarantees a full FIFO never has a read in flight.
    assert property (@(posedge i_clock) disable iff (i_reset) !(fifoFull && inflight_q));
  end

endmodule
